// File: rtl/sdram_txn_scheduler_if.sv
// Shared AHB-Lite request bus seen by the scheduler and by both
// slaves (golden SDRAM model and DUV).
interface sdram_txn_scheduler_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        golden_HREADY;
  logic        duv_HREADY;
  logic [31:0] golden_HRDATA;
  logic [31:0] duv_HRDATA;

  modport master (
    output HADDR, HTRANS, HWRITE, HWDATA,
    input  golden_HREADY, duv_HREADY,
    input  golden_HRDATA, duv_HRDATA
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HWDATA,
    output golden_HREADY, duv_HREADY,
    output golden_HRDATA, duv_HRDATA
  );
endinterface

// File: rtl/sdram_txn_scheduler.sv
// Write pass then read-back pass over NUM_TXN words, comparing golden vs DUV.
// Optional STOP_ON_ERR_EN: finish at the first read mismatch.
module sdram_txn_scheduler #(
  parameter int          NUM_TXN   = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          TIMEOUT   = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  sdram_txn_scheduler_if.master        bus,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout,
  output logic                         cmp_valid,
  output logic [31:0]                  cmp_golden,
  output logic [31:0]                  cmp_duv,
  output logic [15:0]                  err_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [1:0]  T_IDLE = 2'b00;
  localparam logic [1:0]  T_NSEQ = 2'b10;
  localparam logic [15:0] LAST   = 16'(NUM_TXN - 1);
  localparam logic [15:0] TMAX   = 16'(TIMEOUT - 1);

`ifdef STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  state_t      state;
  logic [15:0] idx;
  logic        pass;
  logic [15:0] wcnt;
  logic        gflag;
  logic        dflag;

  logic        last;
  logic [15:0] idx_nx;
  logic [31:0] addr_nx;
  logic        both_rdy;
  logic        g_ok;
  logic        d_ok;
  logic        mismatch;

  assign last     = (idx == LAST);
  assign idx_nx   = last ? 16'd0 : idx + 16'd1;
  assign addr_nx  = BASE_ADDR + {14'd0, idx_nx, 2'b00};
  assign both_rdy = bus.golden_HREADY & bus.duv_HREADY;
  assign g_ok     = gflag | bus.golden_HREADY;
  assign d_ok     = dflag | bus.duv_HREADY;
  // X/Z on either captured word counts as a mismatch
  assign mismatch = (cmp_golden !== cmp_duv);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      pass       <= 1'b0;
      wcnt       <= '0;
      gflag      <= 1'b0;
      dflag      <= 1'b0;
      bus.HADDR  <= '0;
      bus.HTRANS <= T_IDLE;
      bus.HWRITE <= 1'b0;
      bus.HWDATA <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      cmp_valid  <= 1'b0;
      cmp_golden <= '0;
      cmp_duv    <= '0;
      err_count  <= '0;
    end else begin
      cmp_valid <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_ADDR;
            idx        <= '0;
            pass       <= 1'b0;
            wcnt       <= '0;
            gflag      <= 1'b0;
            dflag      <= 1'b0;
            timeout    <= 1'b0;
            err_count  <= '0;
            bus.HADDR  <= BASE_ADDR;
            bus.HTRANS <= T_NSEQ;
            bus.HWRITE <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        S_ADDR: begin
          if (both_rdy) begin
            state      <= S_DATA;
            wcnt       <= '0;
            bus.HTRANS <= T_IDLE;
            bus.HWRITE <= 1'b0;
            bus.HWDATA <= pass ? 32'd0 : {~idx, idx};
          end else if (wcnt == TMAX) begin
            state      <= S_DONE;
            timeout    <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b1;
            bus.HTRANS <= T_IDLE;
            bus.HWRITE <= 1'b0;
          end else begin
            wcnt <= wcnt + 16'd1;
          end
        end
        S_DATA: begin
          // each side completes on its own; first capture is kept
          if (!gflag && bus.golden_HREADY) begin
            gflag      <= 1'b1;
            cmp_golden <= bus.golden_HRDATA;
          end
          if (!dflag && bus.duv_HREADY) begin
            dflag   <= 1'b1;
            cmp_duv <= bus.duv_HRDATA;
          end
          if (g_ok && d_ok) begin
            gflag      <= 1'b0;
            dflag      <= 1'b0;
            wcnt       <= '0;
            bus.HWDATA <= '0;
            if (pass) begin
              state     <= S_CHECK;
              cmp_valid <= 1'b1;
            end else begin
              state      <= S_ADDR;
              idx        <= idx_nx;
              pass       <= last;
              bus.HADDR  <= addr_nx;
              bus.HTRANS <= T_NSEQ;
              bus.HWRITE <= ~last;
            end
          end else if (wcnt == TMAX) begin
            state      <= S_DONE;
            timeout    <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b1;
            gflag      <= 1'b0;
            dflag      <= 1'b0;
            bus.HWDATA <= '0;
          end else begin
            wcnt <= wcnt + 16'd1;
          end
        end
        S_CHECK: begin
          if (mismatch && err_count != 16'hFFFF)
            err_count <= err_count + 16'd1;
          if (last || (STOP && mismatch)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state      <= S_ADDR;
            idx        <= idx_nx;
            wcnt       <= '0;
            bus.HADDR  <= addr_nx;
            bus.HTRANS <= T_NSEQ;
            bus.HWRITE <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_txn_scheduler.sv
// Randomized bench for sdram_txn_scheduler against a transaction-indexed
// model; bench slaves hold word memories and inject DUV read corruption.
module tb_sdram_txn_scheduler;

  localparam int          N    = 4;
  localparam int          TO   = 8;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, done, timeout, cmp_valid;
  logic [31:0] cmp_golden, cmp_duv;
  logic [15:0] err_count;

  sdram_txn_scheduler_if bus();

  sdram_txn_scheduler #(
    .NUM_TXN(N), .BASE_ADDR(BASE), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .busy(busy), .done(done), .timeout(timeout),
    .cmp_valid(cmp_valid), .cmp_golden(cmp_golden),
    .cmp_duv(cmp_duv), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_tot = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- slaves ----------------
  int          mode = 0;
  logic [15:0] corrupt = '0;
  int          cyc = 0;
  logic [31:0] gmem [16];
  logic [31:0] dmem [16];
  int          sa = 0;
  logic        swr = 1'b0;
  logic        gp = 1'b0;
  logic        dp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    case (mode)
      0: begin bus.golden_HREADY = 1'b1; bus.duv_HREADY = 1'b1; end
      1: begin
        bus.golden_HREADY = ($urandom % 4) != 0;
        bus.duv_HREADY    = ($urandom % 4) != 0;
      end
      2: begin bus.golden_HREADY = 1'b1; bus.duv_HREADY = (cyc % 4) == 3; end
      default: begin
        bus.golden_HREADY = 1'b1;
        bus.duv_HREADY    = (bus.HTRANS == 2'b10);
      end
    endcase
  end

  always @(posedge clk) begin
    if (start) begin
      gp <= 1'b0;
      dp <= 1'b0;
    end else if (bus.HTRANS == 2'b10 && bus.golden_HREADY && bus.duv_HREADY) begin
      sa  <= int'((bus.HADDR - BASE) >> 2) & 15;
      swr <= bus.HWRITE;
      gp  <= 1'b1;
      dp  <= 1'b1;
    end else begin
      if (gp && bus.golden_HREADY) begin
        if (swr) gmem[sa] <= bus.HWDATA;
        gp <= 1'b0;
      end
      if (dp && bus.duv_HREADY) begin
        if (swr) dmem[sa] <= bus.HWDATA;
        dp <= 1'b0;
      end
    end
  end

  assign bus.golden_HRDATA = gmem[sa];
  assign bus.duv_HRDATA    = corrupt[sa] ? 32'hDEAD_BEEF : dmem[sa];

  // ---------------- model ----------------
  // m_k walks 0..2N-1: first N are writes, next N are reads of k-N.
  // m_ph: 0 address phase, 1 data phase, 2 compare cycle.
  bit m_busy, m_done, m_to, m_gf, m_df;
  int m_k, m_ph, m_w, m_err;
  bit gr, dr, bad, stop_err;

`ifdef STOP_ON_ERR_EN
  assign stop_err = 1'b1;
`else
  assign stop_err = 1'b0;
`endif

  assign gr  = bus.golden_HREADY;
  assign dr  = bus.duv_HREADY;
  assign bad = (m_k >= N) ? corrupt[(m_k - N) & 15] : 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 0; m_done <= 0; m_to <= 0; m_gf <= 0; m_df <= 0;
      m_k <= 0; m_ph <= 0; m_w <= 0; m_err <= 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy <= 1; m_done <= 0; m_to <= 0; m_gf <= 0; m_df <= 0;
        m_k <= 0; m_ph <= 0; m_w <= 0; m_err <= 0;
      end
    end else if (m_ph == 0) begin
      if (gr && dr) begin
        m_ph <= 1; m_w <= 0;
      end else if (m_w == TO - 1) begin
        m_busy <= 0; m_done <= 1; m_to <= 1;
      end else m_w <= m_w + 1;
    end else if (m_ph == 1) begin
      if ((m_gf || gr) && (m_df || dr)) begin
        m_gf <= 0; m_df <= 0; m_w <= 0;
        if (m_k < N) begin m_k <= m_k + 1; m_ph <= 0; end
        else m_ph <= 2;
      end else if (m_w == TO - 1) begin
        m_busy <= 0; m_done <= 1; m_to <= 1;
      end else begin
        m_w <= m_w + 1; m_gf <= m_gf || gr; m_df <= m_df || dr;
      end
    end else begin
      if (bad) m_err <= (m_err == 65535) ? m_err : m_err + 1;
      if (m_k == 2 * N - 1 || (stop_err && bad)) begin
        m_busy <= 0; m_done <= 1;
      end else begin
        m_k <= m_k + 1; m_ph <= 0; m_w <= 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit          chk_en = 1'b0;
  int          ci;
  logic [15:0] w16;

  always @(negedge clk) begin
    if (chk_en) begin
      ci  = m_k % N;
      w16 = 16'(ci);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("timeout", timeout, m_to);
      chk("err_count", err_count, m_err);
      chk("HTRANS", bus.HTRANS, (m_busy && m_ph == 0) ? 2 : 0);
      chk("HWRITE", bus.HWRITE, m_busy && m_ph == 0 && m_k < N);
      chk("cmp_valid", cmp_valid, m_busy && m_ph == 2);
      if (m_busy && m_ph == 0)
        chk("HADDR", bus.HADDR, BASE + 32'(4 * ci));
      if (m_busy && m_ph == 1 && m_k < N)
        chk("HWDATA", bus.HWDATA, {~w16, w16});
      if (m_busy && m_ph == 2) begin
        chk("cmp_golden", cmp_golden, {~w16, w16});
        chk("cmp_duv", cmp_duv,
            corrupt[ci] ? 32'hDEAD_BEEF : {~w16, w16});
      end
    end
  end

  // ---------------- directed runs ----------------
  int r_busy, r_nsq, r_ncv;

  task automatic run(input int md, input logic [15:0] cm, input bit spur);
    bit ok;
    mode    = md;
    corrupt = cm;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    r_busy = 0; r_nsq = 0; r_ncv = 0; ok = 0;
    chk("first_haddr", bus.HADDR, BASE);
    for (int c = 0; c < 400; c++) begin
      if (busy) r_busy++;
      if (bus.HTRANS == 2'b10) r_nsq++;
      if (cmp_valid) r_ncv++;
      if (done) begin ok = 1; break; end
      start = spur && (c == 4);
      @(negedge clk);
    end
    start = 1'b0;
    chk("run_finished", ok, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin gmem[i] = '0; dmem[i] = '0; end
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_htrans", bus.HTRANS, 0);
    chk("rst_haddr", bus.HADDR, 0);
    chk("rst_err", err_count, 0);
    reset  = 1'b0;
    chk_en = 1'b1;

    run(0, 16'h0, 0);
    chk("zw_busy_cycles", r_busy, 20);
    chk("zw_nonseq", r_nsq, 8);
    chk("zw_cmpv", r_ncv, 4);
    chk("zw_err", err_count, 0);

    run(2, 16'h0, 0);
    chk("slow_done", done, 1);
    chk("slow_err", err_count, 0);
    chk("slow_cmpv", r_ncv, 4);

    run(0, 16'h4, 0);
    chk("bad2_err", err_count, 1);
`ifdef STOP_ON_ERR_EN
    chk("bad2_cmpv", r_ncv, 3);
`else
    chk("bad2_cmpv", r_ncv, 4);
`endif

    run(3, 16'h0, 0);
    chk("to_flag", timeout, 1);
    chk("to_done", done, 1);
    chk("to_busy_cycles", r_busy, 9);
    chk("to_htrans", bus.HTRANS, 0);

    run(0, 16'h0, 1);
    chk("spur_busy_cycles", r_busy, 20);
    chk("spur_timeout", timeout, 0);

    repeat (12) run(1, 16'($urandom & 32'hF), 1'($urandom % 2));

    // abort during the read pass
    mode    = 0;
    corrupt = 16'h1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      bit seen = 0;
      for (int c = 0; c < 100 && !seen; c++) begin
        if (cmp_valid) seen = 1;
        else @(negedge clk);
      end
      chk("abort_reached_read", seen, 1);
    end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_htrans", bus.HTRANS, 0);
    chk("abort_haddr", bus.HADDR, 0);
    chk("abort_err", err_count, 0);
    chk("abort_cmpv", cmp_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    run(0, 16'h0, 0);
    chk("fresh_err", err_count, 0);
    chk("fresh_cmpv", r_ncv, 4);
    chk("fresh_busy_cycles", r_busy, 20);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
